div_seq_unit: RTL and testbench

Iterative radix-2 integer divider with its own sequencing FSM. It serves the divide functional-unit slot of the out-of-order core: it accepts one RV32M divide/remainder op from the divide issue queue and computes it over 32 iterations. It then holds the result, asserting div_ready, until the issue unit grants the CDB with div_done. div_busy back-pressures the issue unit so that only one op is ever in flight.

---
 rtl/div_pkg.sv | 7 +
 rtl/div_iter_datapath.sv | 35 +++
 rtl/div_seq_unit.sv | 97 +++++++++
 tb/tb_div_seq_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared op/state encodings and special-case constants for the sequential divider
package div_pkg;
  typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
  localparam logic [31:0] DIV_BY_ZERO_Q = '1;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
endpackage

// File: rtl/div_iter_datapath.sv
// div_iter_datapath: restoring-division registers, one quotient bit per step
module div_iter_datapath #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);
  logic [XLEN:0]   r;
  logic [XLEN-1:0] q, d;
  logic [XLEN+1:0] diff;
  // shift the next dividend bit into R, then trial-subtract; the top bit is the borrow
  assign diff = {r, q[XLEN-1]} - {2'b00, d};
  always_ff @(posedge clk) begin
    if (!rst) begin
      r <= '0;
      q <= '0;
      d <= '0;
    end else if (load) begin
      r <= '0;
      q <= dividend;
      d <= divisor;
    end else if (step) begin
      r <= diff[XLEN+1] ? {r[XLEN-1:0], q[XLEN-1]} : diff[XLEN:0];
      q <= {q[XLEN-2:0], ~diff[XLEN+1]};
    end
  end
  assign quo = q;
  assign rem = r[XLEN-1:0];
endmodule

// File: rtl/div_seq_unit.sv
// div_seq_unit: RV32M divide/remainder functional unit with its own sequencing FSM
module div_seq_unit
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [1:0]       issue_op,
  input  logic [XLEN-1:0]  issue_rs1,
  input  logic [XLEN-1:0]  issue_rs2,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic             flush,
  input  logic             div_done,
  output logic             div_busy,
  output logic             div_ready,
  output logic [XLEN-1:0]  div_result,
  output logic [TAG_W-1:0] div_tag
);
  div_state_e       state, state_n;
  div_op_e          op_q;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_q;
  logic             sign_q, sign_r;
  logic             is_signed, accept, by_zero, ovf, special, load, step;
  logic [XLEN-1:0]  abs1, abs2, special_res, quo, rem, q_fix, r_fix;
  assign is_signed   = ~issue_op[0];
  assign accept      = (state == IDLE) & issue_valid & ~flush;
  assign by_zero     = issue_rs2 == '0;
  assign ovf         = is_signed & (issue_rs1 == INT_MIN) & (issue_rs2 == '1);
  assign special     = by_zero | ovf;
  assign special_res = issue_op[1] ? (ovf ? '0 : issue_rs1) : (ovf ? INT_MIN : DIV_BY_ZERO_Q);
  assign abs1        = (is_signed & issue_rs1[XLEN-1]) ? -issue_rs1 : issue_rs1;
  assign abs2        = (is_signed & issue_rs2[XLEN-1]) ? -issue_rs2 : issue_rs2;
  assign load        = accept & ~special;
  assign step        = state == CALC;
  assign q_fix       = sign_q ? -quo : quo;
  assign r_fix       = sign_r ? -rem : rem;
  assign div_busy    = state != IDLE;
  assign div_ready   = state == DONE;
  div_iter_datapath #(.XLEN(XLEN)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .dividend (abs1),
    .divisor  (abs2),
    .quo      (quo),
    .rem      (rem)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? (special ? DONE : CALC) : IDLE;
      CALC: state_n = (cnt == CNT_W'(XLEN - 1)) ? FIX : CALC;
      FIX:  state_n = DONE;
      DONE: state_n = div_done ? IDLE : DONE;
    endcase
    if (flush) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      op_q   <= DIV;
      tag_q  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      op_q   <= div_op_e'(issue_op);
      tag_q  <= issue_tag;
      sign_q <= is_signed & (issue_rs1[XLEN-1] ^ issue_rs2[XLEN-1]);
      sign_r <= is_signed & issue_rs1[XLEN-1];
    end else if (step) begin
      cnt <= cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_result <= '0;
      div_tag    <= '0;
    end else if (accept & special) begin
      div_result <= special_res;
      div_tag    <= issue_tag;
    end else if (state == FIX) begin
      div_result <= (op_q == REM || op_q == REMU) ? r_fix : q_fix;
      div_tag    <= tag_q;
    end
  end
endmodule

// File: tb/tb_div_seq_unit.sv
// tb_div_seq_unit: directed vector table plus hand-written hold/flush/reset sequences
module tb_div_seq_unit;
  import div_pkg::*;
  logic        clk = 0;
  logic        rst = 0;
  logic        issue_valid = 0;
  logic [1:0]  issue_op = 0;
  logic [31:0] issue_rs1 = 0, issue_rs2 = 0;
  logic [5:0]  issue_tag = 0;
  logic        flush = 0, div_done = 0;
  logic        div_busy, div_ready;
  logic [31:0] div_result;
  logic [5:0]  div_tag;
  int total = 0, bad = 0;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [5:0]  tag;
    int          lat;
    logic [31:0] res;
  } vec_t;
  vec_t vecs[14];
  div_seq_unit dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_tag(issue_tag),
    .flush(flush), .div_done(div_done), .div_busy(div_busy), .div_ready(div_ready),
    .div_result(div_result), .div_tag(div_tag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] t);
    issue_valid = 1;
    issue_op = op;
    issue_rs1 = a;
    issue_rs2 = b;
    issue_tag = t;
    tick();
    issue_valid = 0;
  endtask
  task automatic run_vec(input vec_t v);
    int n;
    issue(v.op, v.a, v.b, v.tag);
    n = 0;
    while (!div_ready && n < 40) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(v.lat));
    chk("result", div_result, v.res);
    chk("tag", 32'(div_tag), 32'(v.tag));
    chk("busy_in_done", 32'(div_busy), 32'd1);
  endtask
  initial begin
    vecs[0]  = '{DIV,  32'd100,       32'd7,         6'd5,  33, 32'd14};
    vecs[1]  = '{REM,  32'hFFFF_FF9C, 32'd7,         6'd1,  33, 32'hFFFF_FFFE};
    vecs[2]  = '{DIVU, 32'hFFFF_FFFF, 32'd2,         6'd2,  33, 32'h7FFF_FFFF};
    vecs[3]  = '{DIV,  32'd5,         32'd0,         6'd3,  0,  32'hFFFF_FFFF};
    vecs[4]  = '{REM,  32'd5,         32'd0,         6'd4,  0,  32'd5};
    vecs[5]  = '{DIV,  32'h8000_0000, 32'hFFFF_FFFF, 6'd6,  0,  32'h8000_0000};
    vecs[6]  = '{REM,  32'h8000_0000, 32'hFFFF_FFFF, 6'd7,  0,  32'd0};
    vecs[7]  = '{DIV,  32'hFFFF_FFF9, 32'd2,         6'd8,  33, 32'hFFFF_FFFD};
    vecs[8]  = '{REMU, 32'd100,       32'd7,         6'd9,  33, 32'd2};
    vecs[9]  = '{DIVU, 32'd0,         32'd5,         6'd10, 33, 32'd0};
    vecs[10] = '{REM,  32'd7,         32'hFFFF_FFFE, 6'd11, 33, 32'd1};
    vecs[11] = '{REMU, 32'd5,         32'd0,         6'd12, 0,  32'd5};
    vecs[12] = '{DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 6'd13, 33, 32'd0};
    vecs[13] = '{DIV,  32'h8000_0000, 32'd2,         6'd63, 33, 32'hC000_0000};
    tick();
    tick();
    chk("rst_busy", 32'(div_busy), 0);
    chk("rst_ready", 32'(div_ready), 0);
    chk("rst_result", div_result, 0);
    chk("rst_tag", 32'(div_tag), 0);
    rst = 1;
    tick();
    foreach (vecs[i]) begin
      div_done = 1;
      run_vec(vecs[i]);
      tick();
      chk("ready_after_done", 32'(div_ready), 0);
      chk("busy_after_done", 32'(div_busy), 0);
      div_done = 0;
    end
    // result held while the CDB is not granted; new issues ignored
    run_vec('{DIV, 32'd100, 32'd7, 6'd9, 33, 32'd14});
    for (int k = 0; k < 10; k++) begin
      issue_valid = k[0];
      issue_op = DIVU;
      issue_rs1 = 32'd50;
      issue_rs2 = 32'd0;
      issue_tag = 6'd3;
      tick();
      chk("hold_ready", 32'(div_ready), 1);
      chk("hold_result", div_result, 32'd14);
      chk("hold_tag", 32'(div_tag), 32'd9);
      chk("hold_busy", 32'(div_busy), 1);
    end
    issue_valid = 0;
    div_done = 1;
    tick();
    div_done = 0;
    chk("hold_release_ready", 32'(div_ready), 0);
    chk("hold_release_busy", 32'(div_busy), 0);
    tick();
    chk("no_stale_accept", 32'(div_busy), 0);
    // flush mid-calc with a coincident div_done
    div_done = 1;
    issue(DIV, 32'd100, 32'd7, 6'd20);
    for (int k = 0; k < 12; k++) tick();
    flush = 1;
    tick();
    flush = 0;
    div_done = 0;
    chk("flush_busy", 32'(div_busy), 0);
    chk("flush_ready", 32'(div_ready), 0);
    div_done = 1;
    run_vec('{REM, 32'd100, 32'd7, 6'd21, 33, 32'd2});
    tick();
    div_done = 0;
    chk("post_flush_idle", 32'(div_busy), 0);
    // flush in IDLE blocks a coincident issue
    flush = 1;
    issue(DIV, 32'd8, 32'd2, 6'd22);
    flush = 0;
    chk("flush_idle_no_accept", 32'(div_busy), 0);
    // reset mid-calc
    issue(DIV, 32'd100, 32'd7, 6'd30);
    for (int k = 0; k < 10; k++) tick();
    rst = 0;
    tick();
    chk("mid_rst_busy", 32'(div_busy), 0);
    chk("mid_rst_ready", 32'(div_ready), 0);
    chk("mid_rst_result", div_result, 0);
    chk("mid_rst_tag", 32'(div_tag), 0);
    rst = 1;
    tick();
    div_done = 1;
    run_vec('{DIV, 32'd9, 32'd3, 6'd31, 33, 32'd3});
    tick();
    div_done = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
